rot_pipe: RTL and testbench

//  Pipelined, elastic barrel shifter/rotator for N = 2^LOG2_N bit words. It extends the

---
 rtl/rot_pipe.sv | 198 +++++++++++++++++++
 tb/tb_rot_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_pipe.sv
// Elastic pipelined barrel rotator/shifter with valid/ready on both sides.
// Define ROT_ZERO_FLAG_EN to add the registered out_zero result flag.
module rot_pipe #(
    parameter int N         = 64,
    parameter int LOG2_N    = 6,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:N-1]      in_data,
    input  logic [0:LOG2_N-1] in_amt,
    input  logic              in_dir,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:N-1]      out_data,
    output logic [TAG_W-1:0]  out_tag
`ifdef ROT_ZERO_FLAG_EN
    ,
    output logic              out_zero
`endif
);

    localparam int L = (LOG2_N + REG_EVERY - 1) / REG_EVERY;

    function automatic logic reg_after(input int j);
        return ((j + 1) % REG_EVERY == 0) || (j == LOG2_N - 1);
    endfunction

    function automatic int src_stage(input int r);
        return (r == L - 1) ? LOG2_N - 1 : (r + 1) * REG_EVERY - 1;
    endfunction

    // One mux level; sgn is the original MSB carried for arithmetic right
    function automatic logic [0:N-1] shf(
        input logic [0:N-1] x,
        input int           s,
        input logic         dir,
        input logic [1:0]   mode,
        input logic         sgn
    );
        logic [0:N-1] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (!dir) begin
                if (k >= s)             r[k] = x[k-s];
                else if (mode == 2'b01) r[k] = 1'b0;
                else if (mode == 2'b10) r[k] = sgn;
                else                    r[k] = x[k-s+N];
            end else begin
                if (k + s < N)                           r[k] = x[k+s];
                else if (mode == 2'b00 || mode == 2'b11) r[k] = x[k+s-N];
                else                                     r[k] = 1'b0;
            end
        end
        return r;
    endfunction

    logic              st_v    [LOG2_N];
    logic [0:N-1]      st_di   [LOG2_N];
    logic [0:N-1]      st_do   [LOG2_N];
    logic [TAG_W-1:0]  st_tag  [LOG2_N];
    logic              st_dir  [LOG2_N];
    logic [1:0]        st_mode [LOG2_N];
    logic [0:LOG2_N-1] st_amt  [LOG2_N];
    logic              st_sgn  [LOG2_N];

    logic              v_q    [L];
    logic [0:N-1]      d_q    [L];
    logic [TAG_W-1:0]  tag_q  [L];
    logic              dir_q  [L];
    logic [1:0]        mode_q [L];
    logic [0:LOG2_N-1] amt_q  [L];
    logic              sgn_q  [L];

    logic              v_d    [L];
    logic [0:N-1]      d_d    [L];
    logic [TAG_W-1:0]  tag_d  [L];
    logic              dir_d  [L];
    logic [1:0]        mode_d [L];
    logic [0:LOG2_N-1] amt_d  [L];
    logic              sgn_d  [L];

    logic [L:0]        rdy;

    always_comb begin
        for (int j = 0; j < LOG2_N; j++) begin
            st_v[j]    = 1'b0;
            st_di[j]   = '0;
            st_tag[j]  = '0;
            st_dir[j]  = 1'b0;
            st_mode[j] = '0;
            st_amt[j]  = '0;
            st_sgn[j]  = 1'b0;
            if (j == 0) begin
                st_v[j]    = in_valid;
                st_di[j]   = in_data;
                st_tag[j]  = in_tag;
                st_dir[j]  = in_dir;
                st_mode[j] = in_mode;
                st_amt[j]  = in_amt;
                st_sgn[j]  = in_data[0];
            end else if (reg_after(j - 1)) begin
                st_v[j]    = v_q[(j-1)/REG_EVERY];
                st_di[j]   = d_q[(j-1)/REG_EVERY];
                st_tag[j]  = tag_q[(j-1)/REG_EVERY];
                st_dir[j]  = dir_q[(j-1)/REG_EVERY];
                st_mode[j] = mode_q[(j-1)/REG_EVERY];
                st_amt[j]  = amt_q[(j-1)/REG_EVERY];
                st_sgn[j]  = sgn_q[(j-1)/REG_EVERY];
            end else begin
                st_v[j]    = st_v[j-1];
                st_di[j]   = st_do[j-1];
                st_tag[j]  = st_tag[j-1];
                st_dir[j]  = st_dir[j-1];
                st_mode[j] = st_mode[j-1];
                st_amt[j]  = st_amt[j-1];
                st_sgn[j]  = st_sgn[j-1];
            end
            st_do[j] = st_amt[j][j]
                ? shf(st_di[j], N >> (j + 1), st_dir[j], st_mode[j], st_sgn[j])
                : st_di[j];
        end
        for (int r = 0; r < L; r++) begin
            v_d[r]    = st_v[src_stage(r)];
            d_d[r]    = st_do[src_stage(r)];
            tag_d[r]  = st_tag[src_stage(r)];
            dir_d[r]  = st_dir[src_stage(r)];
            mode_d[r] = st_mode[src_stage(r)];
            amt_d[r]  = st_amt[src_stage(r)];
            sgn_d[r]  = st_sgn[src_stage(r)];
        end
    end

    // A slot may load if it or any slot downstream of it has a hole
    always_comb begin
        rdy = '0;
        for (int r = 0; r <= L; r++) begin
            rdy[r] = out_ready;
            for (int k = r; k < L; k++) begin
                if (!v_q[k]) rdy[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < L; r++) begin
                v_q[r]    <= 1'b0;
                d_q[r]    <= '0;
                tag_q[r]  <= '0;
                dir_q[r]  <= 1'b0;
                mode_q[r] <= '0;
                amt_q[r]  <= '0;
                sgn_q[r]  <= 1'b0;
            end
        end else begin
            for (int r = 0; r < L; r++) begin
                if (rdy[r]) begin
                    v_q[r]    <= v_d[r];
                    d_q[r]    <= d_d[r];
                    tag_q[r]  <= tag_d[r];
                    dir_q[r]  <= dir_d[r];
                    mode_q[r] <= mode_d[r];
                    amt_q[r]  <= amt_d[r];
                    sgn_q[r]  <= sgn_d[r];
                end
            end
        end
    end

`ifdef ROT_ZERO_FLAG_EN
    logic zero_q;
    logic zero_d;

    assign zero_d = (d_d[L-1] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (rdy[L-1]) begin
            zero_q <= zero_d;
        end
    end

    assign out_zero = zero_q & v_q[L-1];
`endif

    assign in_ready  = rdy[0];
    assign out_valid = v_q[L-1];
    assign out_data  = d_q[L-1];
    assign out_tag   = tag_q[L-1];

endmodule

// File: tb/tb_rot_pipe.sv
// Randomized and directed bench for rot_pipe (N=8) against a shift/rotate reference model.
// Building with ROT_ZERO_FLAG_EN switches to REG_EVERY=2 and checks out_zero.
module tb_rot_pipe;

    localparam int N  = 8;
    localparam int LG = 3;
`ifdef ROT_ZERO_FLAG_EN
    localparam int RE = 2;
`else
    localparam int RE = 1;
`endif
    localparam int L = (LG + RE - 1) / RE;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_dir;
    logic [1:0] in_mode;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_tag;
`ifdef ROT_ZERO_FLAG_EN
    logic       out_zero;
`endif

    rot_pipe #(.N(N), .LOG2_N(LG), .REG_EVERY(RE), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef ROT_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Numeric view: bit 7 is the MSB, right = toward the LSB
    function automatic logic [7:0] model(input logic [7:0] x, input int a,
                                         input logic dir, input logic [1:0] m);
        logic [7:0] r;
        if (a == 0) return x;
        if (!dir) begin
            if (m == 2'b01)      r = x >> a;
            else if (m == 2'b10) r = 8'($signed(x) >>> a);
            else                 r = 8'((x >> a) | (x << (8 - a)));
        end else begin
            if (m == 2'b00 || m == 2'b11) r = 8'((x << a) | (x >> (8 - a)));
            else                          r = 8'(x << a);
        end
        return r;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic [3:0] t;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic       stall;
    logic [7:0] hold_d;
    logic [3:0] hold_t;
    int         nrecv = 0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_v", 32'(out_valid), 1);
                check("hold_d", 32'(out_data), 32'(hold_d));
                check("hold_t", 32'(out_tag), 32'(hold_t));
            end
            check("in_ready", 32'(in_ready),
                  32'(!(q.size() == L && !out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("data", 32'(out_data), 32'(e.d));
                    check("tag", 32'(out_tag), 32'(e.t));
`ifdef ROT_ZERO_FLAG_EN
                    check("zero", 32'(out_zero), 32'(e.d == 8'h00));
`endif
                    nrecv++;
                end
            end
            if (in_valid && in_ready) begin
                e.d = model(in_data, int'(in_amt), in_dir, in_mode);
                e.t = in_tag;
                q.push_back(e);
            end
            stall  = out_valid && !out_ready;
            hold_d = out_data;
            hold_t = out_tag;
        end
    end

    logic [3:0] tagc = 4'd0;

    task automatic direct(input string nm, input logic [7:0] d,
                          input logic [2:0] a, input logic dir,
                          input logic [1:0] m, input logic [7:0] exp);
        int n;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_dir    = dir;
        in_mode   = m;
        in_tag    = tagc;
        tagc      = tagc + 4'd1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_lat"}, 32'(n), 32'(L));
        check({nm, "_dat"}, 32'(out_data), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx;
        int   base;
        logic acc;
        logic saw_full;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_v", 32'(out_valid), 0);
        check("rst_d", 32'(out_data), 0);
        check("rst_t", 32'(out_tag), 0);
        rst = 1'b0;
        #1;
        check("rst_rdy", 32'(in_ready), 1);
        out_ready = 1'b1;

        direct("rotr",  8'h81, 3'd1, 1'b0, 2'b00, 8'hC0);
        direct("rotl",  8'h81, 3'd1, 1'b1, 2'b00, 8'h03);
        direct("lsl",   8'h81, 3'd3, 1'b1, 2'b01, 8'h08);
        direct("asr",   8'h90, 3'd2, 1'b0, 2'b10, 8'hE4);
        direct("lsr",   8'h90, 3'd2, 1'b0, 2'b01, 8'h24);
        direct("z_rot", 8'h90, 3'd0, 1'b0, 2'b00, 8'h90);
        direct("z_asl", 8'h90, 3'd0, 1'b1, 2'b10, 8'h90);
        direct("z_r11", 8'h90, 3'd0, 1'b1, 2'b11, 8'h90);
        direct("asl",   8'hC3, 3'd2, 1'b1, 2'b10, 8'h0C);
        direct("rot11", 8'h01, 3'd7, 1'b0, 2'b11, 8'h02);
`ifdef ROT_ZERO_FLAG_EN
        direct("zf",    8'h80, 3'd1, 1'b1, 2'b01, 8'h00);
        check("zf_flag", 32'(out_zero), 1);
`endif
        @(posedge clk);

        // Backpressure burst: tags 0..5 with the consumer stalled a while
        idx      = 0;
        acc      = 1'b0;
        saw_full = 1'b0;
        base     = nrecv;
        for (int c = 0; c < 60 && nrecv - base < 6; c++) begin
            @(posedge clk);
            if (acc) idx++;
            #1;
            out_ready = !(c >= 2 && c <= 7);
            in_valid  = (idx < 6);
            in_tag    = 4'(idx);
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom);
            in_dir    = 1'($urandom);
            in_mode   = 2'($urandom);
            #1;
            acc = in_valid && in_ready;
            if (in_valid && !in_ready) saw_full = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_full", 32'(saw_full), 1);
        check("bp_cnt", 32'(nrecv - base), 6);

        // Reset with the pipe holding words
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < L; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA5 + 8'(i);
            in_amt   = 3'd0;
            in_tag   = 4'(i + 8);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("pre_rst_v", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_v", 32'(out_valid), 0);
        check("mid_rst_d", 32'(out_data), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_v", 32'(out_valid), 0);

        // Random sweep with random valid and backpressure
        base = nrecv;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom);
            in_dir    = 1'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 32'(q.size()), 0);
        check("sweep_some", 32'(nrecv - base > 100), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
